cmc_addertree_pipe: RTL and testbench

//  - Parametrised, pipelined signed adder tree: reduces NUM_IN signed IN_W operands to one full-precision sum.
//  - One register stage per tree level; valid/ready flow control with per-stage bubble collapsing.
//  - Successor to the fixed 4:1 combinational CMC tree; used in the CMC datapath wherever reduction depth breaks timing.

---
 rtl/cmc_addertree_pipe.sv | 152 +++++++++++++++
 tb/tb_cmc_addertree_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmc_addertree_pipe.sv
// cmc_addertree_pipe: pipelined signed adder tree, one register stage per level,
// valid/ready flow control with per-stage bubble collapsing.
// Optional feature macro: CMC_ADDERTREE_ACC_EN adds a group accumulate stage
// after the tree (results only on last beats, latency LEVELS+1).
module cmc_addertree_pipe #(
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_data,
    output logic                   out_last
);

    localparam int unsigned LEVELS = $clog2(NUM_IN);
    localparam int unsigned OUT_W  = IN_W + LEVELS;

    // Bit offset of level k inside the flattened operand bus; level k holds
    // NUM_IN>>k operands of IN_W+k bits each.
    function automatic int unsigned lvl_off(input int unsigned k);
        int unsigned o;
        o = 0;
        for (int unsigned m = 0; m < k; m++) begin
            o += (NUM_IN >> m) * (IN_W + m);
        end
        return o;
    endfunction

    localparam int unsigned BUS_W   = lvl_off(LEVELS + 1);
    localparam int unsigned TOP_OFF = lvl_off(LEVELS);

    logic [BUS_W-1:0]  w_bus;
    logic [LEVELS-1:0] w_vld;
    logic [LEVELS-1:0] w_last;
    logic [LEVELS-1:0] w_rdy;
    logic              w_tree_rdy;
    logic              w_tree_vld;
    logic              w_tree_last;
    logic [OUT_W-1:0]  w_tree_sum;

    // Level 0 of the bus is the raw operand vector.
    assign w_bus[NUM_IN*IN_W-1:0] = in_data;

    // A flush cycle never accepts a new vector.
    assign in_ready = w_rdy[0] & ~clr;

    genvar k;
    for (k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned NK = NUM_IN >> k;
        localparam int unsigned WK = IN_W + k;
        localparam int unsigned PW = WK - 1;
        localparam int unsigned PO = lvl_off(k - 1);
        localparam int unsigned CO = lvl_off(k);

        logic [NK*WK-1:0] r_data;
        logic             r_vld;
        logic             r_last;
        logic             w_up_vld;
        logic             w_up_last;
        logic             w_dn_rdy;

        if (k == 1) begin : g_first
            assign w_up_vld  = in_valid;
            assign w_up_last = in_last;
        end else begin : g_inner
            assign w_up_vld  = w_vld[k-2];
            assign w_up_last = w_last[k-2];
        end

        if (k == LEVELS) begin : g_tail
            assign w_dn_rdy = w_tree_rdy;
        end else begin : g_mid
            assign w_dn_rdy = w_rdy[k];
        end

        assign w_rdy[k-1]        = ~r_vld | w_dn_rdy;
        assign w_vld[k-1]        = r_vld;
        assign w_last[k-1]       = r_last;
        assign w_bus[CO +: NK*WK] = r_data;

        // Stage register: pairwise sign-extended sums, loads only when it can move.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld  <= 1'b0;
                r_last <= 1'b0;
                r_data <= '0;
            end else if (clr) begin
                r_vld <= 1'b0;
            end else if (w_rdy[k-1]) begin
                r_vld <= w_up_vld;
                if (w_up_vld) begin
                    r_last <= w_up_last;
                    for (int unsigned j = 0; j < NK; j++) begin
                        r_data[j*WK +: WK] <=
                            WK'($signed(w_bus[PO + (2*j)*PW +: PW])) +
                            WK'($signed(w_bus[PO + (2*j+1)*PW +: PW]));
                    end
                end
            end
        end
    end

    assign w_tree_vld  = w_vld[LEVELS-1];
    assign w_tree_last = w_last[LEVELS-1];
    assign w_tree_sum  = w_bus[TOP_OFF +: OUT_W];

`ifdef CMC_ADDERTREE_ACC_EN
    logic [ACC_W-1:0] r_acc;
    logic             r_acc_clr;
    logic             r_ovld;

    // Accumulate stage only stalls while a finished group total is unaccepted.
    assign w_tree_rdy = ~r_ovld | out_ready;

    // Group accumulator: restart after reset, flush or the previous last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_acc_clr <= 1'b1;
            r_ovld    <= 1'b0;
        end else if (clr) begin
            r_acc     <= '0;
            r_acc_clr <= 1'b1;
            r_ovld    <= 1'b0;
        end else if (w_tree_rdy) begin
            r_ovld <= w_tree_vld & w_tree_last;
            if (w_tree_vld) begin
                r_acc     <= (r_acc_clr ? '0 : r_acc) + ACC_W'($signed(w_tree_sum));
                r_acc_clr <= w_tree_last;
            end
        end
    end

    assign out_valid = r_ovld;
    assign out_data  = r_acc;
    assign out_last  = r_ovld;
`else
    assign w_tree_rdy = out_ready;
    assign out_valid  = w_tree_vld;
    assign out_data   = ACC_W'($signed(w_tree_sum));
    assign out_last   = w_tree_last;
`endif

endmodule

// File: tb/tb_cmc_addertree_pipe.sv
// Testbench for cmc_addertree_pipe: queue-based reference model plus directed
// vectors with literal expectations. Works with or without CMC_ADDERTREE_ACC_EN.
module tb_cmc_addertree_pipe;

    localparam int unsigned ACC_W = 32;
`ifdef CMC_ADDERTREE_ACC_EN
    localparam int LAT = 3;
    localparam bit ACC = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit ACC = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;

    logic         b_clr;
    logic         b_in_valid;
    logic         b_in_ready;
    logic [127:0] b_in_data;
    logic         b_in_last;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [31:0]  b_out_data;
    logic         b_out_last;

    cmc_addertree_pipe #(.NUM_IN(4), .IN_W(16), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    cmc_addertree_pipe #(.NUM_IN(8), .IN_W(16), .ACC_W(ACC_W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] m_acc;
    longint      m_s;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic longint vsum4(input logic [63:0] d);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) s += longint'($signed(d[i*16 +: 16]));
        return s;
    endfunction

    function automatic logic [63:0] mk4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [127:0] mk8(input int v);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(v);
        return r;
    endfunction

    // Reference model: sum of operands (or group totals) in acceptance order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_acc = '0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_out: got out_valid=1 data=%0d expected no result",
                             $signed(out_data));
                end else begin
                    chk("model_out_data", out_data, exp_q[0].data);
                    chk("model_out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (out_ready) got_q.push_back(out_data);
            end
            if (clr) begin
                exp_q.delete();
                m_acc = '0;
            end else if (in_valid && in_ready) begin
                m_s = vsum4(in_data);
                if (ACC) begin
                    m_acc = m_acc + 32'(m_s);
                    if (in_last) begin
                        exp_q.push_back('{data: m_acc, last: 1'b1});
                        m_acc = '0;
                    end
                end else begin
                    exp_q.push_back('{data: 32'(m_s), last: in_last});
                end
            end
        end
    end

    // Offer one vector and wait (bounded) for its acceptance edge.
    task automatic send(input logic [63:0] d, input logic l);
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    int idx, cyc, nacc, kk;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; clr = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        b_clr = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Latency: {1,2,3,4} -> 10 exactly LAT cycles after acceptance
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk4(1, 2, 3, 4); in_last = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("lat_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            chk("lat_early_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", out_data, 32'd10);
        repeat (3) @(negedge clk);

        // Extremes, no wrap
        got_q.delete();
        send(mk4(-32768, -32768, -32768, -32768), 1'b1);
        send(mk4(32767, 32767, 32767, 32767), 1'b1);
        send(mk4(32767, -32768, 1, 0), 1'b1);
        idle(LAT + 3);
        chk("ext_count", 32'(got_q.size()), 32'd3);
        chk("ext_min", got_q[0], 32'hFFFE_0000);
        chk("ext_max", got_q[1], 32'd131068);
        chk("ext_mix", got_q[2], 32'd0);

        // Back-to-back 8 vectors, out_ready pattern 1,0,0 repeating
        got_q.delete();
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 200) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_data   = mk4(idx, -2 * idx, 3, 100 * idx);
            in_last   = ACC ? 1'b1 : 1'(idx & 1);
            out_ready = (cyc % 3 == 0);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        if (idx < 8) begin
            n_cmp++; n_err++;
            $display("FAIL b2b_timeout: got %0d accepted expected 8", idx);
        end
        out_ready = 1'b1;
        idle(LAT + 4);
        chk("b2b_count", 32'(got_q.size()), 32'd8);
        chk("b2b_first", got_q[0], 32'd3);
        chk("b2b_last", got_q[7], 32'd696);

`ifdef CMC_ADDERTREE_ACC_EN
        // Group accumulation: 4+8+12 = 24, then fresh group of 4
        got_q.delete();
        send(mk4(1, 1, 1, 1), 1'b0);
        send(mk4(2, 2, 2, 2), 1'b0);
        send(mk4(3, 3, 3, 3), 1'b1);
        send(mk4(1, 1, 1, 1), 1'b1);
        idle(LAT + 3);
        chk("acc_count", 32'(got_q.size()), 32'd2);
        chk("acc_group", got_q[0], 32'd24);
        chk("acc_restart", got_q[1], 32'd4);
`endif

        // Flush with two vectors in flight; offered vector not accepted
        out_ready = 1'b0;
        send(mk4(9, 9, 9, 9), 1'b1);
        send(mk4(7, 7, 7, 7), 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = mk4(5, 5, 5, 5); in_last = 1'b1; clr = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        got_q.delete();
        out_ready = 1'b1;
        send(mk4(5, 5, 5, 5), 1'b1);
        idle(LAT + 3);
        chk("clr_count", 32'(got_q.size()), 32'd1);
        chk("clr_next", got_q[0], 32'd20);

        // Async reset mid-flight discards the vector
        send(mk4(1, 1, 1, 1), 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("arst_no_output", 32'(out_valid), 32'd0);
        end

        // NUM_IN=8: three stages fill under backpressure, then drain 1/cycle
        b_out_ready = 1'b0;
        nacc = 0; kk = 1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1;
            b_in_data  = mk8(kk);
            @(negedge clk);
            if (b_in_valid && b_in_ready) begin
                nacc++;
                kk++;
            end
        end
        chk("n8_accepted", 32'(nacc), 32'd3);
        chk("n8_in_ready_low", 32'(b_in_ready), 32'd0);
        chk("n8_held_valid", 32'(b_out_valid), 32'd1);
        chk("n8_held_data", b_out_data, 32'd8);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            b_out_ready = 1'b1;
            b_in_data   = mk8(kk);
            @(negedge clk);
            chk("n8_drain_valid", 32'(b_out_valid), 32'd1);
            chk("n8_drain_data", b_out_data, 32'(8 * (c + 1)));
            if (b_in_valid && b_in_ready) kk++;
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
